// File: rtl/pci_bus_arbiter.sv
// -----------------------------------------------------------------------------
// pci_bus_arbiter
//
// Central round-robin arbiter for a shared PCI bus. Samples the active-low
// request lines, hands out one active-low grant at a time, follows FRAME/IRDY
// to see when the granted master starts and finishes its transaction, inserts
// one turnaround cycle between owners and revokes a grant that is not used
// within TIMEOUT clocks.
//
// Ports:
//   clk          bus clock, all state updates on posedge
//   rst          synchronous reset, active high
//   REQ          per-device request, active low (bit i = device i)
//   GNT          per-device grant, active low, at most one bit low
//   FRAME        shared FRAME, active low
//   IRDY         shared IRDY, active low
//   bus_busy     high from grant issue until the end of turnaround
//   owner        index of the last/current granted device
//   timeout_err  one-cycle pulse when a grant is revoked by timeout
// -----------------------------------------------------------------------------
module pci_bus_arbiter #(
  parameter int N_DEV   = 3,
  parameter int OWNER_W = 2,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_DEV-1:0]   REQ,
  output logic [N_DEV-1:0]   GNT,
  input  logic               FRAME,
  input  logic               IRDY,
  output logic               bus_busy,
  output logic [OWNER_W-1:0] owner,
  output logic               timeout_err
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    BUSY,
    TURN
  } state_t;

  localparam logic [7:0]         TCNT_LAST = 8'(TIMEOUT - 1);
  localparam logic [7:0]         TCNT_MAX  = 8'hFF;
  // Pointer starts at the last device so device 0 wins the first arbitration.
  localparam logic [OWNER_W-1:0] PTR_RESET = OWNER_W'(N_DEV - 1);
  localparam logic [OWNER_W:0]   N_DEV_W   = (OWNER_W + 1)'(N_DEV);

  state_t             state, state_nxt;
  logic [OWNER_W-1:0] rr_ptr, rr_ptr_nxt;
  logic [OWNER_W-1:0] owner_nxt;
  logic [OWNER_W-1:0] winner;
  logic               winner_found;
  logic [7:0]         tcnt, tcnt_nxt;
  logic [N_DEV-1:0]   gnt_nxt;
  logic               busy_nxt;
  logic               terr_nxt;
  logic               bus_idle;
  logic               timeout_hit;

  assign bus_idle    = FRAME & IRDY;
  assign timeout_hit = (tcnt == TCNT_LAST);

  // Round-robin search: first requester after rr_ptr, wrapping modulo N_DEV.
  // The sum is one bit wider than the pointer so the wrap cannot overflow.
  always_comb begin
    logic [OWNER_W:0]   sum;
    logic [OWNER_W-1:0] cand;
    // NOTE: every variable assigned in a combinational block gets a default
    // at the top; otherwise paths that skip an assignment infer a latch.
    winner       = '0;
    winner_found = 1'b0;
    sum          = '0;
    cand         = '0;
    for (int i = 1; i <= N_DEV; i++) begin
      sum = {1'b0, rr_ptr} + (OWNER_W + 1)'(i);
      if (sum >= N_DEV_W) sum = sum - N_DEV_W;
      cand = sum[OWNER_W-1:0];
      if (!winner_found && !REQ[cand]) begin
        winner       = cand;
        winner_found = 1'b1;
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    // NOTE: registers take non-blocking assignments so every flop samples the
    // pre-edge value of every other flop, independent of statement order.
    if (rst) begin
      state       <= IDLE;
      GNT         <= '1;
      rr_ptr      <= PTR_RESET;
      owner       <= '0;
      bus_busy    <= 1'b0;
      timeout_err <= 1'b0;
      tcnt        <= '0;
    end else begin
      state       <= state_nxt;
      GNT         <= gnt_nxt;
      rr_ptr      <= rr_ptr_nxt;
      owner       <= owner_nxt;
      bus_busy    <= busy_nxt;
      timeout_err <= terr_nxt;
      tcnt        <= tcnt_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (winner_found && bus_idle) state_nxt = GRANT;
      GRANT: begin
        // FRAME wins over withdrawal and timeout, so a start on the timeout
        // edge is a normal transaction.
        if (!FRAME)                          state_nxt = BUSY;
        else if (REQ[owner] || timeout_hit)  state_nxt = TURN;
      end
      BUSY:  if (bus_idle) state_nxt = TURN;
      TURN:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs and bookkeeping.
  always_comb begin
    gnt_nxt    = '1;
    owner_nxt  = owner;
    rr_ptr_nxt = rr_ptr;
    tcnt_nxt   = tcnt;
    busy_nxt   = bus_busy;
    terr_nxt   = 1'b0;
    unique case (state)
      IDLE: begin
        // A foreign transaction still on the bus blocks the grant.
        if (winner_found && bus_idle) begin
          gnt_nxt[winner] = 1'b0;
          owner_nxt       = winner;
          rr_ptr_nxt      = winner;
          tcnt_nxt        = '0;
          busy_nxt        = 1'b1;
        end
      end
      GRANT: begin
        if (!FRAME) begin
          // Transaction started; grant released, bus stays busy.
        end else if (REQ[owner]) begin
          // Request withdrawn before use.
        end else if (timeout_hit) begin
          terr_nxt = 1'b1;
        end else begin
          gnt_nxt[owner] = 1'b0;
          tcnt_nxt       = (tcnt == TCNT_MAX) ? tcnt : tcnt + 8'd1;
        end
      end
      BUSY: ;
      TURN: busy_nxt = 1'b0;
      default: busy_nxt = 1'b0;
    endcase
  end

endmodule

// File: doc/pci_bus_arbiter.md
Name: pci_bus_arbiter

Overview:
- Central arbiter for the shared PCI bus. Samples the active-low REQ lines of up to N devices and issues one active-low GNT at a time.
- Rotates ownership round-robin. Watches FRAME/IRDY to detect transaction start and end.
- Revokes a grant that is never used within a timeout.
- Sits at top level between the Device instances and the shared AD/C_BE/FRAME/IRDY/TRDY/DEVSEL wires.

Parameters:
- N_DEV, 3, number of requesting devices (2..8).
- OWNER_W, 2, width of owner index; must satisfy 2**OWNER_W >= N_DEV.
- TIMEOUT, 16, posedges GNT may stay asserted without FRAME being sampled low (1..255).

Ports:
- clk  input  1  bus clock; all state updates on posedge.
- rst  input  1  synchronous reset, active-high.
- REQ  input  N_DEV  per-device bus request, active LOW; bit i = device i.
- GNT  output  N_DEV  per-device grant, active LOW, at most one bit 0.
- FRAME  input  1  shared FRAME, active LOW; top level pulls the wire up.
- IRDY  input  1  shared IRDY, active LOW; top level pulls the wire up.
- bus_busy  output  1  high from grant issue until the end of turnaround.
- owner  output  OWNER_W  index of the last/current granted device.
- timeout_err  output  1  one-cycle pulse when a grant is revoked by timeout.

Behaviour:
- All inputs are sampled on posedge clk; devices drive on negedge. All outputs are registered.
- Signal sense: FRAME/IRDY count as asserted only when sampled 0. Bus idle = FRAME=1 and IRDY=1.
- Reset (rst=1 at posedge):
  - GNT = all 1s, state IDLE, rr_ptr = N_DEV-1 (device 0 has top priority first).
  - owner = 0, bus_busy = 0, timeout_err = 0, tcnt = 0.
  - Reset mid-transaction forces GNT high on that same edge. The arbiter does not wait for the bus to go idle.
- Winner selection: first i in order rr_ptr+1, rr_ptr+2, ... (mod N_DEV) with REQ[i]=0. Purely combinational from the registered rr_ptr.
- States:
  - IDLE: if any REQ=0 and bus idle → GNT[winner]=0, owner=winner, rr_ptr=winner, tcnt=0, bus_busy=1, go GRANT. Grant latency is 1 posedge after REQ is sampled low. If the bus is not idle (foreign transaction), stay IDLE.
  - GRANT, evaluated in this priority order:
    1. FRAME sampled 0 → GNT=all 1s, go BUSY.
    2. Else REQ[owner] sampled 1 (request withdrawn) → GNT=all 1s, go TURN.
    3. Else tcnt == TIMEOUT-1 → GNT=all 1s, timeout_err=1 for one cycle, go TURN.
    4. Else tcnt+1.
    - FRAME low on the timeout edge counts as a successful start, so no timeout is reported.
  - BUSY: REQ changes are ignored. When FRAME=1 and IRDY=1 are sampled together → go TURN. FRAME=1 with IRDY=0 (last data phase) stays BUSY.
  - TURN: exactly one idle cycle with GNT all 1s. Then bus_busy=0 and go IDLE. The next grant can therefore appear on the 2nd posedge after the bus goes idle.
- Fairness:
  - rr_ptr updates only on grant issue.
  - A device holding REQ low continuously is not re-granted while any other device has REQ low.
  - A sole requester is re-granted back-to-back, with a TURN cycle between grants.
- Invariants:
  - GNT is never 0 on more than one bit.
  - GNT is never 0 outside GRANT.
  - owner is stable outside IDLE→GRANT edges.
- Counter: tcnt is 8 bits and saturates. It is compared only in GRANT.

Test Plan:
- Reset: rst=1 for 2 cycles with REQ=3'b000 → GNT=3'b111, bus_busy=0, owner=0. First posedge after rst drops gives GNT=3'b110 (device 0).
- Single master: REQ=3'b101 (dev1); FRAME=0 on 2nd posedge after grant, held 3 cycles, then IRDY=1 → GNT=3'b101 for exactly 2 cycles then 3'b111. bus_busy falls one cycle after FRAME=IRDY=1 is sampled; owner=1 throughout.
- Round-robin: REQ=3'b000 held; each master completes a 2-cycle transaction → grant order dev0, dev1, dev2, dev0. There is one TURN cycle between grants and never two GNT bits low.
- Timeout: REQ=3'b110, FRAME held 1, TIMEOUT=16 → GNT[0]=0 for exactly 16 cycles. timeout_err pulses 1 cycle as GNT returns to 1. A subsequent REQ from dev1 is granted after TURN.
- Withdrawal and boundary: grant dev2, then REQ[2]=1 before FRAME → GNT returns 3'b111 the next posedge with timeout_err=0. In a separate run, FRAME=0 sampled on the tcnt=15 edge → BUSY entered with timeout_err=0.
- Reset mid-transaction: assert rst while in BUSY with FRAME=0 → GNT=3'b111, bus_busy=0 on the same posedge. After release, arbitration waits for bus idle before granting.
